// File: rtl/calc_core_p.sv
// calc_core_p: digit-by-digit operand entry for the push-button calculator,
// sequential BCD-to-binary conversion, and add / subtract / shift-add multiply
// with a saturating signed-magnitude result. Every output comes from a flop.
//
// state | meaning
// ENT_A | editing operand A digit by digit
// OPSEL | choosing the operation (ADD, SUB, MUL)
// ENT_B | editing operand B digit by digit
// CONV  | converting A and B to binary, most significant digit first
// EXEC  | running the selected operation
// SHOW  | holding the result until Enter starts a new calculation
module calc_core_p #(
  parameter int DIGITS = 4,
  parameter int W      = 14
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  U,
  input  logic                  LU,
  input  logic                  Enter,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic [DIGITS-1:0]     blink,
  output logic [W-1:0]          result,
  output logic                  neg,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            phase
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned  MAXV      = pow10(DIGITS) - 1;
  localparam logic [2*W-1:0]   MAXV_R    = (2*W)'(MAXV);
  localparam logic [W-1:0]     MAXV_W    = W'(MAXV);
  localparam int               CUR_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int               CNT_W     = (W > 1) ? $clog2(W) : 1;
  localparam logic [CUR_W-1:0] CUR_MAX   = CUR_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(W - 1);
  localparam logic [DIGITS-1:0] BLINK_RST = DIGITS'(1) << (DIGITS - 1);

  typedef enum logic [2:0] {
    ENT_A = 3'd0,
    OPSEL = 3'd1,
    ENT_B = 3'd2,
    CONV  = 3'd3,
    EXEC  = 3'd4,
    SHOW  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  state_t                   state_q, state_d;
  op_t                      op_q, op_d;
  logic [DIGITS-1:0][3:0]   a_dig_q, a_dig_d;
  logic [DIGITS-1:0][3:0]   b_dig_q, b_dig_d;
  logic [CUR_W-1:0]         cursor_q, cursor_d;
  logic [W-1:0]             a_bin_q, a_bin_d;
  logic [W-1:0]             b_bin_q, b_bin_d;
  logic [2*W-1:0]           mcand_q, mcand_d;
  logic [2*W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]      disp_q, disp_d;
  logic [DIGITS-1:0]        blink_q, blink_d;
  logic [W-1:0]             result_q, result_d;
  logic                     neg_q, neg_d;
  logic                     ovf_q, ovf_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [W-1:0]             a_next, b_next;
  logic [2*W-1:0]           acc_n;
  logic [2*W-1:0]           r;
  logic                     r_valid;
  logic                     r_neg;

  // Next-state logic for the sequencer, datapath and output registers.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_dig_d  = a_dig_q;
    b_dig_d  = b_dig_q;
    cursor_d = cursor_q;
    a_bin_d  = a_bin_q;
    b_bin_d  = b_bin_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    a_next   = (a_bin_q << 3) + (a_bin_q << 1) + W'(a_dig_q[cursor_q]);
    b_next   = (b_bin_q << 3) + (b_bin_q << 1) + W'(b_dig_q[cursor_q]);
    acc_n    = acc_q + (b_bin_q[0] ? mcand_q : '0);
    r        = '0;
    r_valid  = 1'b0;
    r_neg    = 1'b0;

    case (state_q)
      ENT_A, ENT_B: begin
        if (Enter) begin
          if (state_q == ENT_A) begin
            state_d = OPSEL;
          end else begin
            state_d  = CONV;
            cursor_d = CUR_MAX;
            a_bin_d  = '0;
            b_bin_d  = '0;
          end
        end else if (LU) begin
          cursor_d = (cursor_q == '0) ? CUR_MAX : cursor_q - CUR_W'(1);
        end else if (U) begin
          if (state_q == ENT_A)
            a_dig_d[cursor_q] = (a_dig_q[cursor_q] >= 4'd9) ? 4'd0 : a_dig_q[cursor_q] + 4'd1;
          else
            b_dig_d[cursor_q] = (b_dig_q[cursor_q] >= 4'd9) ? 4'd0 : b_dig_q[cursor_q] + 4'd1;
        end
      end

      OPSEL: begin
        if (Enter) begin
          state_d  = ENT_B;
          b_dig_d  = '0;
          cursor_d = CUR_MAX;
        end else if (LU) begin
          op_d = op_q;
        end else if (U) begin
          op_d = (op_q == OP_MUL) ? OP_ADD : op_t'(op_q + 2'd1);
        end
      end

      // The cursor doubles as the digit index while converting.
      CONV: begin
        a_bin_d = a_next;
        b_bin_d = b_next;
        if (cursor_q == '0) begin
          state_d = EXEC;
          mcand_d = {{W{1'b0}}, a_next};
          acc_d   = '0;
          cnt_d   = CNT_MAX;
        end else begin
          cursor_d = cursor_q - CUR_W'(1);
        end
      end

      EXEC: begin
        case (op_q)
          OP_ADD: begin
            r       = {{(W-1){1'b0}}, ({1'b0, a_bin_q} + {1'b0, b_bin_q})};
            r_valid = 1'b1;
          end
          OP_SUB: begin
            if (a_bin_q >= b_bin_q) begin
              r = {{W{1'b0}}, a_bin_q - b_bin_q};
            end else begin
              r     = {{W{1'b0}}, b_bin_q - a_bin_q};
              r_neg = 1'b1;
            end
            r_valid = 1'b1;
          end
          OP_MUL: begin
            acc_d   = acc_n;
            mcand_d = mcand_q << 1;
            b_bin_d = b_bin_q >> 1;
            if (cnt_q == '0) begin
              r       = acc_n;
              r_valid = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          default: r_valid = 1'b1;
        endcase

        if (r_valid) begin
          state_d = SHOW;
          neg_d   = r_neg;
          if (r > MAXV_R) begin
            ovf_d    = 1'b1;
            result_d = MAXV_W;
          end else begin
            ovf_d    = 1'b0;
            result_d = r[W-1:0];
          end
        end
      end

      SHOW: begin
        if (Enter) begin
          state_d  = ENT_A;
          a_dig_d  = '0;
          b_dig_d  = '0;
          cursor_d = CUR_MAX;
          op_d     = OP_ADD;
          result_d = '0;
          neg_d    = 1'b0;
          ovf_d    = 1'b0;
        end
      end

      default: state_d = ENT_A;
    endcase

    busy_d = (state_d == CONV) || (state_d == EXEC);
    done_d = (state_d == SHOW) && (state_q != SHOW);

    disp_d  = '0;
    blink_d = '0;
    case (state_d)
      ENT_A: begin
        disp_d            = a_dig_d;
        blink_d[cursor_d] = 1'b1;
      end
      ENT_B: begin
        disp_d            = b_dig_d;
        blink_d[cursor_d] = 1'b1;
      end
      OPSEL: begin
        disp_d[3:0] = {2'b00, op_d};
        blink_d     = '1;
      end
      default: begin
        disp_d  = '0;
        blink_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ENT_A;
      op_q     <= OP_ADD;
      a_dig_q  <= '0;
      b_dig_q  <= '0;
      cursor_q <= CUR_MAX;
      a_bin_q  <= '0;
      b_bin_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
      blink_q  <= BLINK_RST;
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_dig_q  <= a_dig_d;
      b_dig_q  <= b_dig_d;
      cursor_q <= cursor_d;
      a_bin_q  <= a_bin_d;
      b_bin_q  <= b_bin_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      blink_q  <= blink_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign disp_bcd = disp_q;
  assign blink    = blink_q;
  assign result   = result_q;
  assign neg      = neg_q;
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_calc_core_p.sv
// Directed bench for calc_core_p with DIGITS=4, W=14.
module tb_calc_core_p;

  logic        clk;
  logic        clr;
  logic        U;
  logic        LU;
  logic        Enter;
  logic [15:0] disp_bcd;
  logic [3:0]  blink;
  logic [13:0] result;
  logic        neg;
  logic        ovf;
  logic        busy;
  logic        done;
  logic [2:0]  phase;

  int n_cmp = 0;
  int n_err = 0;

  calc_core_p #(.DIGITS(4), .W(14)) dut (
    .clk      (clk),
    .clr      (clr),
    .U        (U),
    .LU       (LU),
    .Enter    (Enter),
    .disp_bcd (disp_bcd),
    .blink    (blink),
    .result   (result),
    .neg      (neg),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done),
    .phase    (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the given pulses; outputs are settled on return.
  task automatic step(input logic u, input logic lu, input logic en);
    U = u; LU = lu; Enter = en;
    @(posedge clk);
    #1;
    U = 1'b0; LU = 1'b0; Enter = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    clr = 1'b0;
  endtask

  // Enters a 4-digit BCD value starting with the cursor on digit 3.
  task automatic enter_operand(input logic [15:0] bcd);
    for (int i = 3; i >= 0; i--) begin
      for (int k = 0; k < int'(bcd[4*i +: 4]); k++) step(1, 0, 0);
      step(0, 1, 0);
    end
  endtask

  task automatic setup_calc(input logic [15:0] a, input int op, input logic [15:0] b);
    do_reset();
    enter_operand(a);
    step(0, 0, 1);
    for (int k = 0; k < op; k++) step(1, 0, 0);
    step(0, 0, 1);
    enter_operand(b);
  endtask

  // Issues Enter in ENT_B and waits for done; lat counts edges from that Enter.
  task automatic go_and_wait(output int lat, output int conv_cnt, output bit held_bad);
    int n;
    step(0, 0, 1);
    n = 1;
    conv_cnt = 0;
    held_bad = 0;
    lat = 0;
    while (n < 60) begin
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (phase === 3'd3) conv_cnt++;
      if (result !== 14'd0 || busy !== 1'b1) held_bad = 1;
      step(0, 0, 0);
      n++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step(1, 0, 1);
    step(1, 0, 1);
    clr = 1'b0;
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    n_cmp++; if (blink !== 4'b1000) begin n_err++; $display("FAIL reset_blink: got %b expected 1000", blink); end
    n_cmp++; if (disp_bcd !== 16'h0000) begin n_err++; $display("FAIL reset_disp: got %h expected 0000", disp_bcd); end
    n_cmp++; if ({result, neg, ovf, busy, done} !== 18'd0) begin
      n_err++; $display("FAIL reset_flags: result=%0d neg=%b ovf=%b busy=%b done=%b expected all 0", result, neg, ovf, busy, done);
    end
  endtask

  task automatic test_edit();
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    n_cmp++; if (disp_bcd !== 16'h3000) begin n_err++; $display("FAIL edit_inc3: got %h expected 3000", disp_bcd); end
    for (int k = 0; k < 7; k++) step(1, 0, 0);
    n_cmp++; if (disp_bcd !== 16'h0000) begin n_err++; $display("FAIL edit_wrap10: got %h expected 0000", disp_bcd); end
    step(0, 1, 0);
    n_cmp++; if (blink !== 4'b0100) begin n_err++; $display("FAIL edit_lu1: got %b expected 0100", blink); end
    for (int k = 0; k < 3; k++) step(0, 1, 0);
    n_cmp++; if (blink !== 4'b1000) begin n_err++; $display("FAIL edit_lu4: got %b expected 1000", blink); end
    step(1, 1, 0);
    n_cmp++; if (blink !== 4'b0100 || disp_bcd !== 16'h0000) begin
      n_err++; $display("FAIL edit_u_lu: blink=%b disp=%h expected 0100/0000", blink, disp_bcd);
    end
    step(1, 0, 0);
    n_cmp++; if (disp_bcd !== 16'h0100) begin n_err++; $display("FAIL edit_digit2: got %h expected 0100", disp_bcd); end
    step(1, 0, 1);
    n_cmp++; if (phase !== 3'd1 || disp_bcd !== 16'h0000 || blink !== 4'b1111) begin
      n_err++; $display("FAIL edit_enter_u: phase=%0d disp=%h blink=%b expected 1/0000/1111", phase, disp_bcd, blink);
    end
    step(1, 0, 0);
    n_cmp++; if (disp_bcd !== 16'h0001) begin n_err++; $display("FAIL opsel_sub: got %h expected 0001", disp_bcd); end
    step(1, 0, 0);
    step(1, 0, 0);
    n_cmp++; if (disp_bcd !== 16'h0000) begin n_err++; $display("FAIL opsel_wrap: got %h expected 0000", disp_bcd); end
    step(1, 1, 0);
    n_cmp++; if (disp_bcd !== 16'h0000) begin n_err++; $display("FAIL opsel_lu_u: got %h expected 0000", disp_bcd); end
    step(0, 0, 1);
    n_cmp++; if (phase !== 3'd2 || blink !== 4'b1000 || disp_bcd !== 16'h0000) begin
      n_err++; $display("FAIL opsel_to_b: phase=%0d blink=%b disp=%h expected 2/1000/0000", phase, blink, disp_bcd);
    end
  endtask

  task automatic test_add();
    int lat, cc; bit hb;
    do_reset();
    enter_operand(16'h1234);
    n_cmp++; if (disp_bcd !== 16'h1234) begin n_err++; $display("FAIL add_a_disp: got %h expected 1234", disp_bcd); end
    step(0, 0, 1);
    step(0, 0, 1);
    enter_operand(16'h0567);
    n_cmp++; if (disp_bcd !== 16'h0567) begin n_err++; $display("FAIL add_b_disp: got %h expected 0567", disp_bcd); end
    go_and_wait(lat, cc, hb);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL add_latency: got %0d expected 6", lat); end
    n_cmp++; if (cc !== 4) begin n_err++; $display("FAIL add_conv_cycles: got %0d expected 4", cc); end
    n_cmp++; if (hb !== 1'b0) begin n_err++; $display("FAIL add_held: got %b expected 0", hb); end
    n_cmp++; if (result !== 14'd1801 || neg !== 1'b0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL add_result: result=%0d neg=%b ovf=%b expected 1801/0/0", result, neg, ovf);
    end
    n_cmp++; if (phase !== 3'd5 || busy !== 1'b0 || blink !== 4'b0000 || disp_bcd !== 16'h0000) begin
      n_err++; $display("FAIL add_show: phase=%0d busy=%b blink=%b disp=%h expected 5/0/0000/0000", phase, busy, blink, disp_bcd);
    end
    step(1, 1, 0);
    n_cmp++; if (done !== 1'b0 || result !== 14'd1801 || phase !== 3'd5) begin
      n_err++; $display("FAIL add_done_pulse: done=%b result=%0d phase=%0d expected 0/1801/5", done, result, phase);
    end
    step(0, 0, 1);
    n_cmp++; if (phase !== 3'd0 || result !== 14'd0 || blink !== 4'b1000 || disp_bcd !== 16'h0000) begin
      n_err++; $display("FAIL show_enter_clear: phase=%0d result=%0d blink=%b disp=%h expected 0/0/1000/0000", phase, result, blink, disp_bcd);
    end
  endtask

  task automatic test_sub();
    int lat, cc; bit hb;
    setup_calc(16'h0025, 1, 16'h0130);
    go_and_wait(lat, cc, hb);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL sub_latency: got %0d expected 6", lat); end
    n_cmp++; if (result !== 14'd105 || neg !== 1'b1 || ovf !== 1'b0) begin
      n_err++; $display("FAIL sub_result: result=%0d neg=%b ovf=%b expected 105/1/0", result, neg, ovf);
    end
  endtask

  task automatic test_mul();
    int lat, cc; bit hb;
    setup_calc(16'h0099, 2, 16'h0101);
    go_and_wait(lat, cc, hb);
    n_cmp++; if (lat !== 19) begin n_err++; $display("FAIL mul_latency: got %0d expected 19", lat); end
    n_cmp++; if (hb !== 1'b0) begin n_err++; $display("FAIL mul_held: got %b expected 0", hb); end
    n_cmp++; if (result !== 14'd9999 || ovf !== 1'b0 || neg !== 1'b0) begin
      n_err++; $display("FAIL mul_9999: result=%0d ovf=%b neg=%b expected 9999/0/0", result, ovf, neg);
    end
    setup_calc(16'h0100, 2, 16'h0100);
    go_and_wait(lat, cc, hb);
    n_cmp++; if (result !== 14'd9999 || ovf !== 1'b1) begin
      n_err++; $display("FAIL mul_sat: result=%0d ovf=%b expected 9999/1", result, ovf);
    end
  endtask

  task automatic test_busy();
    int n;
    bit seen;
    setup_calc(16'h0099, 2, 16'h0101);
    step(0, 0, 1);
    for (int k = 0; k < 6; k++) step(0, 0, 0);
    n_cmp++; if (phase !== 3'd4 || busy !== 1'b1) begin n_err++; $display("FAIL busy_in_exec: phase=%0d busy=%b expected 4/1", phase, busy); end
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(1, 1, 1);
    n_cmp++; if (phase !== 3'd4 || result !== 14'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL busy_ignore: phase=%0d result=%0d done=%b expected 4/0/0", phase, result, done);
    end
    n = 11;
    seen = 0;
    while (n < 60) begin
      if (done === 1'b1) begin seen = 1; break; end
      step(0, 0, 0);
      n++;
    end
    n_cmp++; if (!seen || n !== 19) begin n_err++; $display("FAIL busy_latency: got %0d expected 19", seen ? n : -1); end
    n_cmp++; if (result !== 14'd9999 || ovf !== 1'b0) begin
      n_err++; $display("FAIL busy_result: result=%0d ovf=%b expected 9999/0", result, ovf);
    end
  endtask

  task automatic test_clr_mid();
    bit done_seen;
    setup_calc(16'h0099, 2, 16'h0101);
    done_seen = 0;
    step(0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0);
      if (done === 1'b1) done_seen = 1;
    end
    n_cmp++; if (phase !== 3'd4) begin n_err++; $display("FAIL clr_mid_exec: phase=%0d expected 4", phase); end
    clr = 1'b1;
    step(1, 0, 1);
    clr = 1'b0;
    if (done === 1'b1) done_seen = 1;
    n_cmp++; if (phase !== 3'd0 || blink !== 4'b1000 || disp_bcd !== 16'h0000 || busy !== 1'b0 || result !== 14'd0 || neg !== 1'b0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL clr_mid_state: phase=%0d blink=%b disp=%h busy=%b result=%0d neg=%b ovf=%b expected reset", phase, blink, disp_bcd, busy, result, neg, ovf);
    end
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0);
      if (done === 1'b1) done_seen = 1;
    end
    n_cmp++; if (done_seen !== 1'b0 || phase !== 3'd0) begin
      n_err++; $display("FAIL clr_mid_no_done: done_seen=%b phase=%0d expected 0/0", done_seen, phase);
    end
  endtask

  initial begin
    clr = 1'b1; U = 1'b0; LU = 1'b0; Enter = 1'b0;
    test_reset();
    test_edit();
    test_add();
    test_sub();
    test_mul();
    test_busy();
    test_clr_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
